// File: rtl/prn_pkg.sv
// Shared types and LFSR helpers for the x^6+x^5+1 pattern checker.
package prn_pkg;

    typedef enum logic [1:0] {SEED_A, SEED_B, VERIFY, LOCKED} prn_state_e;

    localparam int TAP0 = 5;  // prn[0]
    localparam int TAP1 = 3;  // prn[1]
    localparam int TAP2 = 1;  // prn[2]
    localparam int FB_A = 5;
    localparam int FB_B = 4;

    function automatic logic [5:0] prn_step(input logic [5:0] s);
        return {s[4:0], s[FB_A] ^ s[FB_B]};
    endfunction

    function automatic logic [2:0] prn_taps(input logic [5:0] s);
        return {s[TAP2], s[TAP1], s[TAP0]};
    endfunction

    // Two consecutive samples fully determine the state at the first one.
    function automatic logic [5:0] prn_seed(input logic [2:0] a, input logic [2:0] b);
        return {a[0], b[0], a[1], b[1], a[2], b[2]};
    endfunction

endpackage

// File: rtl/prn_predictor.sv
// Holds the predicted generator state P and the pattern expected at the next strobe.
module prn_predictor
    import prn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       adv_i,
    input  logic [5:0] seed_i,
    output logic [2:0] exp_o
);

    logic [5:0] p_q, p_d;
    logic [2:0] exp_q, exp_d;

    always_comb begin
        p_d   = p_q;
        exp_d = exp_q;
        if (load_i) begin
            p_d = prn_step(seed_i);
        end else if (adv_i) begin
            p_d = prn_step(p_q);
        end
        // P is the state at the last strobe, so the next strobe sees step(P).
        if (load_i || adv_i) begin
            exp_d = prn_taps(prn_step(p_d));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q   <= '0;
            exp_q <= '0;
        end else begin
            p_q   <= p_d;
            exp_q <= exp_d;
        end
    end

    assign exp_o = exp_q;

endmodule

// File: rtl/prn_checker.sv
// Lock/verify FSM and error counters for the 3-bit PRN stream.
module prn_checker
    import prn_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             smp_en,
    input  logic [2:0]       prn,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(LOSS_CNT + 1);

    prn_state_e       state_q, state_d;
    logic [2:0]       a_q, a_d;
    logic [GW-1:0]    good_q, good_d;
    logic [MW-1:0]    miss_q, miss_d;
    logic             locked_q, locked_d;
    logic             pulse_q, pulse_d;
    logic [ERR_W-1:0] cnt_q, cnt_d;

    logic       load, adv, err, match;
    logic [2:0] exp_pat;
    logic [5:0] seed;

    assign seed  = prn_seed(a_q, prn);
    assign match = (prn == exp_pat);

    prn_predictor u_pred (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .adv_i  (adv),
        .seed_i (seed),
        .exp_o  (exp_pat)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        good_d   = good_q;
        miss_d   = miss_q;
        locked_d = locked_q;
        load     = 1'b0;
        adv      = 1'b0;
        err      = 1'b0;
        if (smp_en) begin
            case (state_q)
                SEED_A: begin
                    a_d     = prn;
                    state_d = SEED_B;
                end
                SEED_B: begin
                    if (seed == 6'd0) begin
                        a_d = prn;
                    end else begin
                        load    = 1'b1;
                        good_d  = '0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    adv = 1'b1;
                    if (match) begin
                        if (good_q == GW'(LOCK_CNT - 1)) begin
                            state_d  = LOCKED;
                            miss_d   = '0;
                            locked_d = 1'b1;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        a_d     = prn;
                        state_d = SEED_B;
                    end
                end
                LOCKED: begin
                    adv = 1'b1;
                    if (match) begin
                        miss_d = '0;
                    end else begin
                        err = 1'b1;
                        if (miss_q == MW'(LOSS_CNT - 1)) begin
                            state_d  = SEED_A;
                            miss_d   = '0;
                            locked_d = 1'b0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end
                end
                default: state_d = SEED_A;
            endcase
        end
        pulse_d = err;
        cnt_d   = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (err && (cnt_q != {ERR_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SEED_A;
            a_q      <= '0;
            good_q   <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_prn_checker.sv
// Directed bench: a reference generator drives two checkers (default and small-counter variant).
module tb_prn_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        smp_en = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [2:0]  prn = 3'd0;
    logic        locked, err_pulse;
    logic [15:0] err_cnt;
    logic        locked2, err_pulse2;
    logic [2:0]  err_cnt2;

    int          n_chk = 0;
    int          n_err = 0;
    logic [5:0]  g;
    logic        pulse_cap, pulse2_cap;

    always #5 clk = ~clk;

    prn_checker dut (
        .clk(clk), .rst(rst), .smp_en(smp_en), .prn(prn), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    prn_checker #(.LOCK_CNT(8), .LOSS_CNT(16), .ERR_W(3)) dut2 (
        .clk(clk), .rst(rst), .smp_en(smp_en), .prn(prn), .clr_cnt(clr_cnt),
        .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2)
    );

    function automatic logic [5:0] gen_step(input logic [5:0] s);
        return {s[4:0], s[5] ^ s[4]};
    endfunction

    function automatic logic [2:0] gen_taps(input logic [5:0] s);
        return {s[1], s[3], s[5]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One strobe every 4 clocks; pulses captured in the cycle after the strobe edge.
    task automatic strobe_raw(input logic [2:0] p, input logic clr);
        @(negedge clk);
        prn = p; smp_en = 1'b1; clr_cnt = clr;
        @(negedge clk);
        pulse_cap = err_pulse; pulse2_cap = err_pulse2;
        smp_en = 1'b0; clr_cnt = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic strobe(input logic [2:0] x, input logic clr);
        logic [2:0] p;
        p = gen_taps(g) ^ x;
        g = gen_step(g);
        strobe_raw(p, clr);
    endtask

    initial begin
        g = 6'b000001;
        repeat (3) @(negedge clk);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_pulse", 32'(err_pulse), 32'd0);
        chk("rst_cnt", 32'(err_cnt), 32'd0);
        chk("rst_p", 32'(dut.u_pred.p_q), 32'd0);
        rst = 1'b1;

        // clean lock
        repeat (2) strobe(3'b000, 1'b0);
        chk("seed_p", 32'(dut.u_pred.p_q), 32'b000010);
        repeat (7) strobe(3'b000, 1'b0);
        chk("lock_early", 32'(locked), 32'd0);
        strobe(3'b000, 1'b0);
        chk("lock_10", 32'(locked), 32'd1);
        chk("lock_cnt0", 32'(err_cnt), 32'd0);
        chk("lock2_10", 32'(locked2), 32'd1);

        // single error while locked
        strobe(3'b010, 1'b0);
        chk("err1_pulse", 32'(pulse_cap), 32'd1);
        chk("err1_cnt", 32'(err_cnt), 32'd1);
        chk("err1_locked", 32'(locked), 32'd1);
        strobe(3'b000, 1'b0);
        chk("err1_next_pulse", 32'(pulse_cap), 32'd0);
        chk("err1_next_cnt", 32'(err_cnt), 32'd1);

        // clear without a strobe
        @(negedge clk); clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        chk("clr_idle", 32'(err_cnt), 32'd0);

        // loss and reacquire
        repeat (3) strobe(3'b010, 1'b0);
        chk("loss3_locked", 32'(locked), 32'd1);
        strobe(3'b010, 1'b0);
        chk("loss4_pulse", 32'(pulse_cap), 32'd1);
        chk("loss4_cnt", 32'(err_cnt), 32'd4);
        chk("loss4_locked", 32'(locked), 32'd0);
        repeat (9) strobe(3'b000, 1'b0);
        chk("relock_early", 32'(locked), 32'd0);
        strobe(3'b000, 1'b0);
        chk("relock", 32'(locked), 32'd1);
        chk("relock_cnt", 32'(err_cnt), 32'd4);

        // async reset between clock edges, right after a mismatch pulse
        @(negedge clk);
        prn = gen_taps(g) ^ 3'b010; smp_en = 1'b1; g = gen_step(g);
        @(posedge clk);
        #1 smp_en = 1'b0;
        chk("prerst_pulse", 32'(err_pulse), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_cnt", 32'(err_cnt), 32'd0);
        chk("arst_pulse", 32'(err_pulse), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // zero seed then valid sequence
        g = 6'b000001;
        repeat (3) strobe_raw(3'b000, 1'b0);
        chk("zero_locked", 32'(locked), 32'd0);
        chk("zero_p", 32'(dut.u_pred.p_q), 32'd0);
        repeat (2) strobe(3'b000, 1'b0);
        chk("zero_seed_p", 32'(dut.u_pred.p_q), 32'b000010);
        repeat (7) strobe(3'b000, 1'b0);
        chk("zero_lock_early", 32'(locked), 32'd0);
        strobe(3'b000, 1'b0);
        chk("zero_lock", 32'(locked), 32'd1);
        chk("zero_lock2", 32'(locked2), 32'd1);

        // saturation and clear on the 3-bit counter
        repeat (6) strobe(3'b010, 1'b0);
        chk("sat6_cnt", 32'(err_cnt2), 32'd6);
        repeat (4) strobe(3'b010, 1'b0);
        chk("sat10_cnt", 32'(err_cnt2), 32'd7);
        chk("sat10_pulse", 32'(pulse2_cap), 32'd1);
        chk("sat10_locked", 32'(locked2), 32'd1);
        strobe(3'b010, 1'b1);
        chk("clr_mis_cnt", 32'(err_cnt2), 32'd0);
        chk("clr_mis_pulse", 32'(pulse2_cap), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/prn_checker.md
# prn_checker

Receive-side companion to the 3-bit pseudo-random pattern generator. Samples the 3-bit `prn` pattern on a sample strobe, rebuilds the 6-bit x^6+x^5+1 Fibonacci LFSR state from two consecutive samples, then predicts each later sample. It reports lock, per-sample mismatches and a saturating error count. Sits in the `clk` domain at the far end of the stimulus path; the strobe comes from the same clock divider that advances the generator.

## Interface
- `LOCK_CNT`, 8: consecutive matches in VERIFY needed to assert `locked` (≥1).
- `LOSS_CNT`, 4: consecutive mismatches in LOCKED that drop lock (≥1).
- `ERR_W`, 16: width of `err_cnt`.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `smp_en`  in  1  one-cycle strobe; `prn` is valid this cycle.
- `prn`  in  3  observed pattern: `prn[0]`=D5, `prn[1]`=D3, `prn[2]`=D1 of the generator state.
- `clr_cnt`  in  1  synchronous clear of `err_cnt`.
- `locked`  out  1  predictor is in lock.
- `err_pulse`  out  1  one-cycle flag for a mismatch while locked.
- `err_cnt`  out  ERR_W  saturating mismatch count, LOCKED state only.

## Operation
- Generator step: S'[k]=S[k-1] for k=1..5; S'[0]=S[5]^S[4]. Period 63. The all-zero state is illegal.
- Seeding from samples a (time t) and b (time t+1): S_t = {D5=a[0], D4=b[0], D3=a[1], D2=b[1], D1=a[2], D0=b[2]}. Prediction register P <= step(S_t), which equals S_{t+1}.
- Each strobe after seeding: expected = taps of step(P), compared with `prn`; then P <= step(P) whether or not the sample matched.
- States:
  - SEED_A: capture a; go to SEED_B.
  - SEED_B: capture b and form S_t. If S_t is all-zero, treat b as the new a and stay in SEED_B. Otherwise load P and go to VERIFY with good count 0.
  - VERIFY: a match increments the good count; reaching LOCK_CNT goes to LOCKED. A mismatch treats the current sample as a and goes to SEED_B.
  - LOCKED: a match clears the miss count. A mismatch pulses `err_pulse`, increments `err_cnt` and the miss count; reaching LOSS_CNT goes to SEED_A and deasserts `locked`.
- `err_cnt` saturates at all-ones and holds across loss of lock.
- `clr_cnt` takes priority over an increment in the same cycle: `err_cnt`=0, but `err_pulse` still fires.
- When `smp_en` is low, state, P and all counters hold.

## Timing
- Reset values: state SEED_A, P=0, good/miss counts 0, `locked`=0, `err_pulse`=0, `err_cnt`=0.
- All outputs are registered. The response to a strobe in cycle n is visible in cycle n+1.
- `locked` rises in the cycle after the LOCK_CNT-th consecutive match strobe.
- `locked` falls in the cycle after the LOSS_CNT-th consecutive mismatch strobe. That last strobe also produces an `err_pulse` and counts.
- `err_pulse` is exactly one cycle wide per mismatching strobe. Back-to-back strobes give back-to-back pulses.
- Minimum strobe spacing is one cycle. Lock is acquired no earlier than LOCK_CNT+2 strobes after reset.
- Reset asserted mid-operation returns every register to its reset value immediately, with no dependence on the clock.

## Structure
- Package `prn_pkg` holds:
  - state enum {SEED_A, SEED_B, VERIFY, LOCKED};
  - constants for the tap positions (5,3,1) and the feedback taps (5,4);
  - function `prn_step` (6-bit next state);
  - function `prn_taps` (6-bit state to 3-bit pattern).
- Sub-module `prn_predictor` holds P, with seed-load and advance controls and a registered `expected` output. The FSM and counters live in `prn_checker`.

## Test plan
- **Clean lock:** generator seeded 000001, strobes every 4 clocks. `prn` sequence 000,100,000,010,000,001,100,… Required: seed gives S0=000001; `locked`=1 one cycle after the 10th strobe (2 seed + 8 matches); `err_cnt`=0.
- **Single error while locked:** XOR `prn[1]` on one strobe. Required: one `err_pulse`, `err_cnt`=1, `locked` stays 1, next strobe matches.
- **Loss and reacquire:** 4 consecutive corrupted strobes. Required: `err_cnt`=4 and `locked`=0 after the 4th. Relock after 10 further clean strobes; `err_cnt` holds at 4.
- **Zero seed:** feed 000,000,000 then a valid sequence. Required: stays in SEED_B, no false lock, locks normally afterwards.
- **Saturation and clear:** ERR_W=3 with 10 mismatches while locked (LOSS_CNT=16). Required: `err_cnt` stops at 7. `clr_cnt` in the same cycle as a mismatch gives `err_cnt`=0 and `err_pulse`=1.
- **Async reset mid-lock:** drive `rst` low between clock edges. Required: `locked`, `err_cnt` and `err_pulse` go to 0 immediately; full reacquisition after release.
